// File: rtl/hdc_pkg.sv
// hdc_pkg: shared state type and width helpers
// for the HDC window bundling path.
package hdc_pkg;

   typedef enum logic [1:0] {
      ACCUM,
      THRESH,
      SEND,
      WAIT_ACK
   } bundler_state_e;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bundle_counter_bank.sv
// bundle_counter_bank: one saturating-free counter per
// dimension, bulk clear, vector increment, slice read.
module bundle_counter_bank
   import hdc_pkg::*;
#(
   parameter int DIMENSIONS = 10000,
   parameter int PAR_BITS   = 10,
   parameter int CNT_W      = 9,
   parameter int SEL_W      = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_i,
   input  logic                      inc_en_i,
   input  logic [DIMENSIONS-1:0]     inc_vec_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [PAR_BITS*CNT_W-1:0] slice_o
);

   localparam int IDX_W = idx_width(DIMENSIONS);

   logic [CNT_W-1:0] cnt_q [DIMENSIONS];

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         for (int d = 0; d < DIMENSIONS; d++)
            cnt_q[d] <= '0;
      end else if (inc_en_i) begin
         for (int d = 0; d < DIMENSIONS; d++)
            cnt_q[d] <= cnt_q[d] + CNT_W'(inc_vec_i[d]);
      end
   end

   always_comb begin
      logic [IDX_W-1:0] idx;
      idx     = '0;
      slice_o = '0;
      for (int j = 0; j < PAR_BITS; j++) begin
         idx = IDX_W'(int'(sel_i) * PAR_BITS + j);
         slice_o[j*CNT_W +: CNT_W] = cnt_q[idx];
      end
   end

endmodule

// File: rtl/window_bundler.sv
// window_bundler: majority-bundles WINDOW_LEN sample
// hypervectors and hands the result to the classifier.
module window_bundler
   import hdc_pkg::*;
#(
   parameter int DIMENSIONS = 10000,
   parameter int PAR_BITS   = 10,
   parameter int WINDOW_LEN = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIMENSIONS-1:0] sample_hv,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   input  logic                  sample_op,
   input  logic                  sample_label,
   input  logic                  flush,
   output logic                  cls_en,
   input  logic                  cls_done,
   output logic [DIMENSIONS-1:0] window_hv,
   output logic                  cls_op,
   output logic                  cls_label,
   output logic [15:0]           window_count
);

   localparam int CNT_W    = cnt_width(WINDOW_LEN);
   localparam int NSLICE   = DIMENSIONS / PAR_BITS;
   localparam int SEL_W    = idx_width(NSLICE);
   localparam int HV_IDX_W = idx_width(DIMENSIONS);
   localparam logic [CNT_W-1:0] HALF     = CNT_W'(WINDOW_LEN / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LEN - 1);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NSLICE - 1);

   bundler_state_e        state_q;
   logic [CNT_W-1:0]      scnt_q;
   logic [SEL_W-1:0]      sel_q;
   logic [DIMENSIONS-1:0] hv_q;
   logic                  op_q;
   logic                  label_q;
   logic                  low_seen_q;
   logic [15:0]           wcnt_q;

   logic                      accept;
   logic                      abort;
   logic                      release_w;
   logic [PAR_BITS*CNT_W-1:0] slice_cnt;
   logic [PAR_BITS-1:0]       slice_bits;
   logic [HV_IDX_W-1:0]       wr_base;

   assign sample_ready = !rst && (state_q == ACCUM);
   assign accept       = sample_valid && sample_ready && !flush;
   assign abort        = flush && (state_q == ACCUM || state_q == THRESH);
   assign release_w    = (state_q == WAIT_ACK) && low_seen_q && cls_done;
   // Start pulse fires in the SEND cycle itself to meet the latency target.
   assign cls_en       = !rst && (state_q == SEND) && cls_done;
   assign wr_base      = HV_IDX_W'(int'(sel_q) * PAR_BITS);

   assign window_hv    = hv_q;
   assign cls_op       = op_q;
   assign cls_label    = label_q;
   assign window_count = wcnt_q;

   bundle_counter_bank #(
      .DIMENSIONS(DIMENSIONS),
      .PAR_BITS  (PAR_BITS),
      .CNT_W     (CNT_W),
      .SEL_W     (SEL_W)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (abort || release_w),
      .inc_en_i (accept),
      .inc_vec_i(sample_hv),
      .sel_i    (sel_q),
      .slice_o  (slice_cnt)
   );

   // Strict majority: a tie on an even window resolves to 0.
   always_comb begin
      slice_bits = '0;
      for (int j = 0; j < PAR_BITS; j++)
         slice_bits[j] = slice_cnt[j*CNT_W +: CNT_W] > HALF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         scnt_q     <= '0;
         sel_q      <= '0;
         hv_q       <= '0;
         op_q       <= 1'b0;
         label_q    <= 1'b0;
         low_seen_q <= 1'b0;
         wcnt_q     <= '0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (abort) begin
                  scnt_q <= '0;
               end else if (accept) begin
                  if (scnt_q == '0) begin
                     op_q    <= sample_op;
                     label_q <= sample_label;
                  end
                  scnt_q <= scnt_q + 1'b1;
                  if (scnt_q == LAST_CNT) begin
                     state_q <= THRESH;
                     sel_q   <= '0;
                  end
               end
            end
            THRESH: begin
               if (abort) begin
                  state_q <= ACCUM;
                  scnt_q  <= '0;
                  sel_q   <= '0;
               end else begin
                  hv_q[wr_base +: PAR_BITS] <= slice_bits;
                  if (sel_q == LAST_SEL) begin
                     state_q <= SEND;
                  end else begin
                     sel_q <= sel_q + 1'b1;
                  end
               end
            end
            SEND: begin
               if (cls_done) begin
                  state_q    <= WAIT_ACK;
                  low_seen_q <= 1'b0;
               end
            end
            WAIT_ACK: begin
               if (!cls_done) begin
                  low_seen_q <= 1'b1;
               end else if (low_seen_q) begin
                  state_q    <= ACCUM;
                  scnt_q     <= '0;
                  low_seen_q <= 1'b0;
                  wcnt_q     <= wcnt_q + 1'b1;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

endmodule
